// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the multi-word CLA sequencer.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word counter width; a single-word operand still needs a 1-bit counter.
  function automatic int cnt_width(input int nwords);
    return (nwords <= 1) ? 1 : $clog2(nwords);
  endfunction

endpackage

// File: rtl/cla_word_sequencer_if.sv
// Producer/consumer handshake bundle for the multi-word CLA sequencer.
interface cla_word_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4
);
  logic                      i_valid;
  logic                      o_ready;
  logic [WIDTH*NWORDS-1:0]   i_A;
  logic [WIDTH*NWORDS-1:0]   i_B;
  logic                      i_Cin;
  logic                      o_valid;
  logic                      i_ready;
  logic [WIDTH*NWORDS-1:0]   o_Sum;
  logic                      o_Cout;
  logic                      o_busy;

  modport master (
    output i_valid, i_A, i_B, i_Cin, i_ready,
    input  o_ready, o_valid, o_Sum, o_Cout, o_busy
  );

  modport slave (
    input  i_valid, i_A, i_B, i_Cin, i_ready,
    output o_ready, o_valid, o_Sum, o_Cout, o_busy
  );
endinterface

// File: rtl/cla_word_sequencer_cla.sv
// WIDTH-bit carry-lookahead adder: every carry is a flat sum of
// generate/propagate products, so no carry depends on another carry.
module CarryLookAheadAdder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             term;

  assign g = i_A & i_B;
  assign p = i_A ^ i_B;

  // Lookahead carries: c[i] = OR over j<i of g[j]&p[j+1..i-1], plus cin&p[0..i-1].
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = i_Cin;
    for (int i = 1; i <= WIDTH; i++) begin
      for (int j = -1; j < i; j++) begin
        term = (j < 0) ? i_Cin : g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        c[i] = c[i] | term;
      end
    end
  end

  assign o_Sum  = p ^ c[WIDTH-1:0];
  assign o_Cout = c[WIDTH];
endmodule

// File: rtl/cla_word_sequencer.sv
// Multi-precision adder: streams one WIDTH-bit word per cycle, LSW first,
// through a single CLA and chains the carry between words in a register.
module cla_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cla_word_sequencer_if.slave  bus
);
  localparam int TW = WIDTH * NWORDS;
  localparam int CW = cnt_width(NWORDS);

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   a_q;
  logic [TW-1:0]   b_q;
  logic [TW-1:0]   sum_q;
  logic            carry_q;
  logic            cout_q;
  logic [CW-1:0]   cnt_q;
  logic            last_word;
  logic [WIDTH-1:0] cla_sum;
  logic            cla_cout;

  assign last_word = (cnt_q == CW'(NWORDS - 1));

  CarryLookAheadAdder #(.WIDTH(WIDTH)) u_cla (
    .i_A   (a_q[WIDTH-1:0]),
    .i_B   (b_q[WIDTH-1:0]),
    .i_Cin (carry_q),
    .o_Sum (cla_sum),
    .o_Cout(cla_cout)
  );

  // Next-state decode; acceptance only in IDLE, no overlap with DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid) state_d = RUN;
      RUN:     if (last_word)   state_d = DONE;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Word counter and result registers (visible outputs, so they reset).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state_q == IDLE && bus.i_valid) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CW'(1);
      sum_q[int'(cnt_q)*WIDTH +: WIDTH] <= cla_sum;
      if (last_word) cout_q <= cla_cout;
    end
  end

  // Operand shift registers and inter-word carry; pure datapath, no reset.
  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && bus.i_valid) begin
      a_q     <= bus.i_A;
      b_q     <= bus.i_B;
      carry_q <= bus.i_Cin;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> WIDTH;
      b_q     <= b_q >> WIDTH;
      carry_q <= cla_cout;
    end
  end

  assign bus.o_ready = (state_q == IDLE) && !i_rst;
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_Sum   = sum_q;
  assign bus.o_Cout  = cout_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer: a 4x4-word and a 4x1-word instance, checked
// against an arithmetic A+B+Cin model with exact latency expectations.
module tb_cla_word_sequencer;
  logic clk = 1'b0;
  logic rst4;
  logic rst1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] last_sum  [2];
  logic [63:0] last_cout [2];

  always #5 clk = ~clk;

  cla_word_sequencer_if #(.WIDTH(4), .NWORDS(4)) if4 ();
  cla_word_sequencer_if #(.WIDTH(4), .NWORDS(1)) if1 ();

  cla_word_sequencer #(.WIDTH(4), .NWORDS(4)) dut4 (
    .i_clk(clk), .i_rst(rst4), .bus(if4.slave)
  );
  cla_word_sequencer #(.WIDTH(4), .NWORDS(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .bus(if1.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input int sel, input logic v, input logic [63:0] a,
                     input logic [63:0] b, input logic cin, input logic rdy);
    if (sel == 1) begin
      if1.i_valid = v; if1.i_A = a[3:0]; if1.i_B = b[3:0];
      if1.i_Cin = cin; if1.i_ready = rdy;
    end else begin
      if4.i_valid = v; if4.i_A = a[15:0]; if4.i_B = b[15:0];
      if4.i_Cin = cin; if4.i_ready = rdy;
    end
  endtask

  function automatic logic [63:0] f_sum(input int sel);
    return (sel == 1) ? 64'(if1.o_Sum) : 64'(if4.o_Sum);
  endfunction
  function automatic logic [63:0] f_cout(input int sel);
    return (sel == 1) ? 64'(if1.o_Cout) : 64'(if4.o_Cout);
  endfunction
  function automatic logic [63:0] f_valid(input int sel);
    return (sel == 1) ? 64'(if1.o_valid) : 64'(if4.o_valid);
  endfunction
  function automatic logic [63:0] f_ready(input int sel);
    return (sel == 1) ? 64'(if1.o_ready) : 64'(if4.o_ready);
  endfunction
  function automatic logic [63:0] f_busy(input int sel);
    return (sel == 1) ? 64'(if1.o_busy) : 64'(if4.o_busy);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One full operation, entered and left at a negedge in IDLE.
  // While busy the producer keeps waving random data with random i_valid,
  // which the DUT must ignore.
  task automatic do_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input int stall);
    int          n;
    logic [63:0] mask;
    logic [63:0] tot;
    logic [63:0] exp_sum;
    logic [63:0] exp_cout;
    n        = (sel == 1) ? 1 : 4;
    mask     = (64'd1 << (4 * n)) - 64'd1;
    tot      = (a & mask) + (b & mask) + 64'(cin);
    exp_sum  = tot & mask;
    exp_cout = (tot >> (4 * n)) & 64'd1;

    chk("idle_ready", f_ready(sel), 64'd1);
    chk("idle_busy",  f_busy(sel),  64'd0);
    chk("idle_valid", f_valid(sel), 64'd0);
    chk("idle_sum_hold",  f_sum(sel),  last_sum[sel]);
    chk("idle_cout_hold", f_cout(sel), last_cout[sel]);
    drv(sel, 1'b1, a, b, cin, 1'($urandom_range(0, 1)));
    @(negedge clk);
    chk("run_busy",  f_busy(sel),  64'd1);
    chk("run_ready", f_ready(sel), 64'd0);
    for (int k = 1; k <= n; k++) begin
      drv(sel, 1'($urandom_range(0, 1)), rnd64(), rnd64(),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("latency_valid", f_valid(sel), 64'(k == n));
    end
    for (int s = 0; s <= stall; s++) begin
      chk("done_valid", f_valid(sel), 64'd1);
      chk("done_ready", f_ready(sel), 64'd0);
      chk("done_sum",   f_sum(sel),   exp_sum);
      chk("done_cout",  f_cout(sel),  exp_cout);
      drv(sel, 1'($urandom_range(0, 1)), rnd64(), rnd64(),
          1'($urandom_range(0, 1)), 1'(s == stall));
      @(negedge clk);
    end
    last_sum[sel]  = exp_sum;
    last_cout[sel] = exp_cout;
  endtask

  initial begin
    last_sum[0] = '0; last_sum[1] = '0;
    last_cout[0] = '0; last_cout[1] = '0;

    // Reset held for 3 cycles with random inputs on both instances.
    rst4 = 1'b1;
    rst1 = 1'b1;
    drv(0, 1'b1, rnd64(), rnd64(), 1'b1, 1'b1);
    drv(1, 1'b1, rnd64(), rnd64(), 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int sel = 0; sel < 2; sel++) begin
        chk("rst_ready", f_ready(sel), 64'd0);
        chk("rst_valid", f_valid(sel), 64'd0);
        chk("rst_busy",  f_busy(sel),  64'd0);
        chk("rst_sum",   f_sum(sel),   64'd0);
        chk("rst_cout",  f_cout(sel),  64'd0);
      end
      drv(0, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'b1);
      drv(1, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'b1);
    end
    rst4 = 1'b0;
    rst1 = 1'b0;
    drv(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drv(1, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_ready4", f_ready(0), 64'd1);
    chk("post_rst_ready1", f_ready(1), 64'd1);

    // Directed cases on the 4-word instance.
    do_op(0, 64'h1234, 64'h4321, 1'b0, 0);
    do_op(0, 64'hFFFF, 64'h0000, 1'b1, 0);
    do_op(0, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 3);
    do_op(0, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 0);

    // Reset during the second RUN cycle abandons the operation.
    drv(0, 1'b1, 64'h0F0F, 64'h1111, 1'b1, 1'b1);
    @(negedge clk);
    chk("mid_run1_valid", f_valid(0), 64'd0);
    drv(0, 1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mid_run2_valid", f_valid(0), 64'd0);
    rst4 = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",  f_busy(0),  64'd0);
    chk("mid_rst_ready", f_ready(0), 64'd0);
    chk("mid_rst_sum",   f_sum(0),   64'd0);
    chk("mid_rst_cout",  f_cout(0),  64'd0);
    rst4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", f_valid(0), 64'd0);
      chk("mid_rst_idle",     f_ready(0), 64'd1);
    end
    last_sum[0]  = '0;
    last_cout[0] = '0;
    do_op(0, 64'h8000, 64'h8000, 1'b0, 1);

    // Back-to-back random traffic with random consumer stalls.
    for (int i = 0; i < 1000; i++)
      do_op(0, rnd64(), rnd64(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    drv(0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++)
      do_op(1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    drv(1, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
